// File: rtl/ahb3lite_pkg.sv
// AHB3-Lite shared definitions: transfer/response encodings, the address-phase
// bundle carried by the hold buffers and the slave-side mux, and small HTRANS helpers.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int AHB_ADDR_W = 32;

  typedef struct packed {
    logic [AHB_ADDR_W-1:0] haddr;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
    logic                  hmastlock;
  } ahb_addr_phase_t;

  localparam ahb_addr_phase_t ADDR_PHASE_ZERO = '{
    haddr:     {AHB_ADDR_W{1'b0}},
    hwrite:    1'b0,
    hsize:     3'b000,
    hburst:    3'b000,
    hprot:     4'b0000,
    hmastlock: 1'b0
  };

  // NONSEQ or SEQ: a real transfer that needs a data phase.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

  // SEQ or BUSY: the master is inside a burst and must keep the bus.
  function automatic logic htrans_in_burst(input logic [1:0] htrans);
    return (htrans == HTRANS_SEQ) || (htrans == HTRANS_BUSY);
  endfunction

endpackage

// File: rtl/ahb3lite_arb_input_stage.sv
// Per-master front end of the arbiter: detects a live request, parks a losing
// address phase in a hold buffer (pending), and gates HREADY/HRESP back to the master.
module ahb3lite_arb_input_stage
  import ahb3lite_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hsel,
  input  logic            xfer,
  input  ahb_addr_phase_t live,
  input  logic            issue,
  input  logic            slv_hready,
  input  logic            slv_hresp,
  input  logic            dph_own,
  output logic            req,
  output logic            pending,
  output ahb_addr_phase_t hold,
  output logic            hready,
  output logic            hresp
);

  logic            live_req_s;
  logic            pending_r;
  ahb_addr_phase_t hold_r;

  // Data-phase owner sees the slave; a parked master is stalled; anyone else gets zero-wait OKAY.
  always_comb begin
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    if (dph_own) begin
      hready = slv_hready;
      hresp  = slv_hresp;
    end else if (pending_r) begin
      hready = 1'b0;
      hresp  = HRESP_OKAY;
    end else begin
      hready = 1'b1;
      hresp  = HRESP_OKAY;
    end
  end

  // A live request only counts when the master actually sees its address phase accepted.
  assign live_req_s = hsel & xfer & hready;
  assign req        = pending_r | live_req_s;
  assign pending    = pending_r;
  assign hold       = hold_r;

  // Hold buffer: capture an accepted-but-not-issued request, release it when it reaches the slave.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 1'b0;
      hold_r    <= ADDR_PHASE_ZERO;
    end else if (pending_r) begin
      pending_r <= !issue;
      hold_r    <= hold_r;
    end else if (live_req_s && !issue) begin
      pending_r <= 1'b1;
      hold_r    <= live;
    end else begin
      pending_r <= 1'b0;
      hold_r    <= hold_r;
    end
  end

endmodule

// File: rtl/ahb3lite_master_arb.sv
// Merges MASTERS AHB3-Lite master ports (0=dbg, 1=dat, 2=ins) onto one slave port.
// Default arbitration is fixed priority (lowest index wins). Defining
// AHB3LITE_ARB_RR_EN selects round-robin after the last grant, with dbg still preempting.
// Bursts (SEQ/BUSY) and locked sequences keep the bus with the current address owner.
module ahb3lite_master_arb
  import ahb3lite_pkg::*;
#(
  parameter int MASTERS    = 3,
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [MASTERS-1:0]    mst_HSEL,
  input  logic [HADDR_SIZE-1:0] mst_HADDR     [MASTERS],
  input  logic [HDATA_SIZE-1:0] mst_HWDATA    [MASTERS],
  input  logic [MASTERS-1:0]    mst_HWRITE,
  input  logic [2:0]            mst_HSIZE     [MASTERS],
  input  logic [2:0]            mst_HBURST    [MASTERS],
  input  logic [3:0]            mst_HPROT     [MASTERS],
  input  logic [1:0]            mst_HTRANS    [MASTERS],
  input  logic [MASTERS-1:0]    mst_HMASTLOCK,
  output logic [HDATA_SIZE-1:0] mst_HRDATA    [MASTERS],
  output logic [MASTERS-1:0]    mst_HREADY,
  output logic [MASTERS-1:0]    mst_HRESP,
  output logic                  slv_HSEL,
  output logic [HADDR_SIZE-1:0] slv_HADDR,
  output logic [HDATA_SIZE-1:0] slv_HWDATA,
  output logic                  slv_HWRITE,
  output logic [2:0]            slv_HSIZE,
  output logic [2:0]            slv_HBURST,
  output logic [3:0]            slv_HPROT,
  output logic [1:0]            slv_HTRANS,
  output logic                  slv_HMASTLOCK,
  input  logic [HDATA_SIZE-1:0] slv_HRDATA,
  input  logic                  slv_HREADY,
  input  logic                  slv_HRESP
);

  localparam int IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  ahb_addr_phase_t  live_s [MASTERS];
  ahb_addr_phase_t  hbuf_s [MASTERS];
  ahb_addr_phase_t  ap_s;
  logic [MASTERS-1:0] req_s, req_q_s, pending_s, issue_s, dph_own_s;
  logic [IDX_W-1:0] win_idx_s, owner_r, dph_owner_r;
  logic             win_vld_s, lock_hold_s, dph_valid_r;
`ifdef AHB3LITE_ARB_RR_EN
  int               cand_s;
`endif

  for (genvar g = 0; g < MASTERS; g++) begin : g_mst
    assign live_s[g] = '{
      haddr:     mst_HADDR[g],
      hwrite:    mst_HWRITE[g],
      hsize:     mst_HSIZE[g],
      hburst:    mst_HBURST[g],
      hprot:     mst_HPROT[g],
      hmastlock: mst_HMASTLOCK[g]
    };
    assign issue_s[g]    = win_vld_s && (win_idx_s == IDX_W'(g)) && slv_HREADY;
    assign dph_own_s[g]  = dph_valid_r && (dph_owner_r == IDX_W'(g));
    assign mst_HRDATA[g] = slv_HRDATA;

    ahb3lite_arb_input_stage u_stage (
      .clk        (HCLK),
      .rst_n      (HRESETn),
      .hsel       (mst_HSEL[g]),
      .xfer       (htrans_active(mst_HTRANS[g])),
      .live       (live_s[g]),
      .issue      (issue_s[g]),
      .slv_hready (slv_HREADY),
      .slv_hresp  (slv_HRESP),
      .dph_own    (dph_own_s[g]),
      .req        (req_s[g]),
      .pending    (pending_s[g]),
      .hold       (hbuf_s[g]),
      .hready     (mst_HREADY[g]),
      .hresp      (mst_HRESP[g])
    );
  end

  // Requests are ignored while reset is asserted so the slave side stays IDLE.
  assign req_q_s = req_s & {MASTERS{HRESETn}};

  // Arbiter: burst/lock hold for the address owner, otherwise fixed priority or round-robin.
  always_comb begin
    win_vld_s   = 1'b0;
    win_idx_s   = {IDX_W{1'b0}};
`ifdef AHB3LITE_ARB_RR_EN
    cand_s      = 0;
`endif
    lock_hold_s = HRESETn && !pending_s[owner_r] &&
                  (htrans_in_burst(mst_HTRANS[owner_r]) || mst_HMASTLOCK[owner_r]);
    if (lock_hold_s) begin
      win_vld_s = 1'b1;
      win_idx_s = owner_r;
    end else begin
`ifdef AHB3LITE_ARB_RR_EN
      if (req_q_s[0]) begin
        win_vld_s = 1'b1;
        win_idx_s = {IDX_W{1'b0}};
      end else begin
        for (int k = 1; k <= MASTERS; k++) begin
          cand_s = (int'(owner_r) + k) % MASTERS;
          if (req_q_s[cand_s[IDX_W-1:0]] && !win_vld_s) begin
            win_vld_s = 1'b1;
            win_idx_s = cand_s[IDX_W-1:0];
          end else begin
            win_vld_s = win_vld_s;
          end
        end
      end
`else
      for (int k = 0; k < MASTERS; k++) begin
        if (req_q_s[k[IDX_W-1:0]] && !win_vld_s) begin
          win_vld_s = 1'b1;
          win_idx_s = k[IDX_W-1:0];
        end else begin
          win_vld_s = win_vld_s;
        end
      end
`endif
    end
  end

  // Address mux: parked requests replay from their buffer as NONSEQ, live ones pass straight through.
  always_comb begin
    slv_HSEL   = 1'b0;
    slv_HTRANS = HTRANS_IDLE;
    ap_s       = ADDR_PHASE_ZERO;
    if (win_vld_s) begin
      if (pending_s[win_idx_s]) begin
        slv_HSEL   = 1'b1;
        slv_HTRANS = HTRANS_NONSEQ;
        ap_s       = hbuf_s[win_idx_s];
      end else begin
        slv_HSEL   = mst_HSEL[win_idx_s];
        slv_HTRANS = mst_HTRANS[win_idx_s];
        ap_s       = live_s[win_idx_s];
      end
    end else begin
      slv_HSEL   = 1'b0;
      slv_HTRANS = HTRANS_IDLE;
    end
  end

  assign slv_HADDR     = ap_s.haddr;
  assign slv_HWRITE    = ap_s.hwrite;
  assign slv_HSIZE     = ap_s.hsize;
  assign slv_HBURST    = ap_s.hburst;
  assign slv_HPROT     = ap_s.hprot;
  assign slv_HMASTLOCK = ap_s.hmastlock;

  // Address owner and data-phase owner advance only when the slave accepts the address phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner_r     <= {IDX_W{1'b0}};
      dph_owner_r <= {IDX_W{1'b0}};
      dph_valid_r <= 1'b0;
    end else if (slv_HREADY) begin
      owner_r     <= win_vld_s ? win_idx_s : owner_r;
      dph_owner_r <= win_idx_s;
      dph_valid_r <= win_vld_s && slv_HSEL && htrans_active(slv_HTRANS);
    end else begin
      owner_r     <= owner_r;
      dph_owner_r <= dph_owner_r;
      dph_valid_r <= dph_valid_r;
    end
  end

  // Write data follows the data-phase owner; quiet when no data phase is in flight.
  always_comb begin
    if (dph_valid_r) begin
      slv_HWDATA = mst_HWDATA[dph_owner_r];
    end else begin
      slv_HWDATA = {HDATA_SIZE{1'b0}};
    end
  end

endmodule

// File: tb/tb_ahb3lite_master_arb.sv
// Directed bench for ahb3lite_master_arb: inputs are driven 1 time unit after
// each rising edge, outputs are checked 3 units later (well before the next edge).
module tb_ahb3lite_master_arb;
  import ahb3lite_pkg::*;

  localparam int M = 3;

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic [M-1:0]    mst_HSEL, mst_HWRITE, mst_HMASTLOCK;
  logic [31:0]     mst_HADDR  [M];
  logic [31:0]     mst_HWDATA [M];
  logic [2:0]      mst_HSIZE  [M];
  logic [2:0]      mst_HBURST [M];
  logic [3:0]      mst_HPROT  [M];
  logic [1:0]      mst_HTRANS [M];
  logic [31:0]     mst_HRDATA [M];
  logic [M-1:0]    mst_HREADY, mst_HRESP;
  logic            slv_HSEL, slv_HWRITE, slv_HMASTLOCK;
  logic [31:0]     slv_HADDR, slv_HWDATA;
  logic [2:0]      slv_HSIZE, slv_HBURST;
  logic [3:0]      slv_HPROT;
  logic [1:0]      slv_HTRANS;
  logic [31:0]     slv_HRDATA;
  logic            slv_HREADY, slv_HRESP;

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  ahb3lite_master_arb #(.MASTERS(3), .HADDR_SIZE(32), .HDATA_SIZE(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .mst_HSEL(mst_HSEL), .mst_HADDR(mst_HADDR), .mst_HWDATA(mst_HWDATA),
    .mst_HWRITE(mst_HWRITE), .mst_HSIZE(mst_HSIZE), .mst_HBURST(mst_HBURST),
    .mst_HPROT(mst_HPROT), .mst_HTRANS(mst_HTRANS), .mst_HMASTLOCK(mst_HMASTLOCK),
    .mst_HRDATA(mst_HRDATA), .mst_HREADY(mst_HREADY), .mst_HRESP(mst_HRESP),
    .slv_HSEL(slv_HSEL), .slv_HADDR(slv_HADDR), .slv_HWDATA(slv_HWDATA),
    .slv_HWRITE(slv_HWRITE), .slv_HSIZE(slv_HSIZE), .slv_HBURST(slv_HBURST),
    .slv_HPROT(slv_HPROT), .slv_HTRANS(slv_HTRANS), .slv_HMASTLOCK(slv_HMASTLOCK),
    .slv_HRDATA(slv_HRDATA), .slv_HREADY(slv_HREADY), .slv_HRESP(slv_HRESP)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [1:0] m, input logic [1:0] tr, input logic [31:0] a,
                     input logic wr, input logic [2:0] bu);
    mst_HSEL[m]   = (tr != HTRANS_IDLE);
    mst_HTRANS[m] = tr;
    mst_HADDR[m]  = a;
    mst_HWRITE[m] = wr;
    mst_HBURST[m] = bu;
  endtask

  task automatic idle_all();
    drv(2'd0, HTRANS_IDLE, 32'h0, 1'b0, 3'b000);
    drv(2'd1, HTRANS_IDLE, 32'h0, 1'b0, 3'b000);
    drv(2'd2, HTRANS_IDLE, 32'h0, 1'b0, 3'b000);
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn       = 1'b0;
    slv_HREADY    = 1'b1;
    slv_HRESP     = HRESP_OKAY;
    slv_HRDATA    = 32'h0;
    mst_HMASTLOCK = 3'b000;
    for (int i = 0; i < M; i++) begin
      mst_HWDATA[i] = 32'h0;
      mst_HSIZE[i]  = 3'b010;
      mst_HPROT[i]  = 4'b0011;
    end
    idle_all();
    #3;
    // reset state
    chk("rst_hready", 32'(mst_HREADY), 32'h7);
    chk("rst_hresp", 32'(mst_HRESP), 32'h0);
    chkb("rst_hsel", slv_HSEL, 1'b0);
    chk("rst_htrans", 32'(slv_HTRANS), 32'h0);
    chk("rst_haddr", slv_HADDR, 32'h0);
    cyc();
    HRESETn = 1'b1;

    // 1: lone dat read, same-cycle pass-through, no stall
    cyc();
    drv(2'd1, HTRANS_NONSEQ, 32'h100, 1'b0, 3'b000);
    #3;
    chk("t1_haddr", slv_HADDR, 32'h100);
    chk("t1_htrans", 32'(slv_HTRANS), 32'h2);
    chk("t1_hprot", 32'(slv_HPROT), 32'h3);
    chkb("t1_hready1", mst_HREADY[1], 1'b1);
    cyc();
    drv(2'd1, HTRANS_IDLE, 32'h0, 1'b0, 3'b000);
    slv_HRDATA = 32'h1111_1111;
    #3;
    chk("t1_hrdata1", mst_HRDATA[1], 32'h1111_1111);
    chkb("t1_hready1_dph", mst_HREADY[1], 1'b1);
    chk("t1_idle", 32'(slv_HTRANS), 32'h0);

    // 2: dbg and ins collide, ins parked one cycle then replayed as NONSEQ
    cyc();
    drv(2'd0, HTRANS_NONSEQ, 32'h2000, 1'b0, 3'b000);
    drv(2'd2, HTRANS_NONSEQ, 32'h200, 1'b0, 3'b000);
    #3;
    chk("t2_haddr_dbg", slv_HADDR, 32'h2000);
    cyc();
    idle_all();
    slv_HRDATA = 32'hAAAA_0000;
    #3;
    chkb("t2_ins_stall", mst_HREADY[2], 1'b0);
    chk("t2_haddr_ins", slv_HADDR, 32'h200);
    chk("t2_htrans_ins", 32'(slv_HTRANS), 32'h2);
    chk("t2_hrdata0", mst_HRDATA[0], 32'hAAAA_0000);
    cyc();
    slv_HRDATA = 32'h0000_BBBB;
    #3;
    chkb("t2_ins_ready", mst_HREADY[2], 1'b1);
    chk("t2_hrdata2", mst_HRDATA[2], 32'h0000_BBBB);
    chk("t2_idle", 32'(slv_HTRANS), 32'h0);

    // 3: dat INCR4 burst is not interrupted by dbg
    cyc();
    drv(2'd1, HTRANS_NONSEQ, 32'h40, 1'b0, 3'b011);
    #3;
    chk("t3_beat0", slv_HADDR, 32'h40);
    cyc();
    drv(2'd1, HTRANS_SEQ, 32'h44, 1'b0, 3'b011);
    drv(2'd0, HTRANS_NONSEQ, 32'h3000, 1'b0, 3'b000);
    #3;
    chk("t3_beat1", slv_HADDR, 32'h44);
    cyc();
    drv(2'd1, HTRANS_SEQ, 32'h48, 1'b0, 3'b011);
    drv(2'd0, HTRANS_IDLE, 32'h0, 1'b0, 3'b000);
    #3;
    chk("t3_beat2", slv_HADDR, 32'h48);
    chkb("t3_dbg_stall", mst_HREADY[0], 1'b0);
    cyc();
    drv(2'd1, HTRANS_SEQ, 32'h4C, 1'b0, 3'b011);
    #3;
    chk("t3_beat3", slv_HADDR, 32'h4C);
    cyc();
    drv(2'd1, HTRANS_IDLE, 32'h0, 1'b0, 3'b000);
    #3;
    chk("t3_dbg_addr", slv_HADDR, 32'h3000);
    chk("t3_dbg_trans", 32'(slv_HTRANS), 32'h2);
    cyc();
    #3;
    chkb("t3_dbg_ready", mst_HREADY[0], 1'b1);

    // 4: dat write with three slave wait states; ins parked meanwhile
    cyc();
    drv(2'd1, HTRANS_NONSEQ, 32'h500, 1'b1, 3'b000);
    #3;
    chkb("t4_hwrite", slv_HWRITE, 1'b1);
    cyc();
    drv(2'd1, HTRANS_IDLE, 32'h0, 1'b0, 3'b000);
    drv(2'd2, HTRANS_NONSEQ, 32'h600, 1'b0, 3'b000);
    mst_HWDATA[1] = 32'hDEAD_BEEF;
    slv_HREADY = 1'b0;
    #3;
    chk("t4_wdata_w1", slv_HWDATA, 32'hDEAD_BEEF);
    chkb("t4_dat_wait1", mst_HREADY[1], 1'b0);
    cyc();
    drv(2'd2, HTRANS_IDLE, 32'h0, 1'b0, 3'b000);
    #3;
    chk("t4_wdata_w2", slv_HWDATA, 32'hDEAD_BEEF);
    chkb("t4_dat_wait2", mst_HREADY[1], 1'b0);
    chkb("t4_ins_parked", mst_HREADY[2], 1'b0);
    cyc();
    #3;
    chk("t4_wdata_w3", slv_HWDATA, 32'hDEAD_BEEF);
    cyc();
    slv_HREADY = 1'b1;
    #3;
    chkb("t4_dat_done", mst_HREADY[1], 1'b1);
    chk("t4_wdata_last", slv_HWDATA, 32'hDEAD_BEEF);
    chk("t4_ins_addr", slv_HADDR, 32'h600);

    // 5: two-cycle ERROR on ins data phase; dat parked then still issued
    cyc();
    slv_HREADY = 1'b0;
    slv_HRESP  = HRESP_ERROR;
    drv(2'd1, HTRANS_NONSEQ, 32'h700, 1'b0, 3'b000);
    #3;
    chk("t5_hresp_c1", 32'(mst_HRESP), 32'h4);
    chkb("t5_ins_wait", mst_HREADY[2], 1'b0);
    cyc();
    slv_HREADY = 1'b1;
    drv(2'd1, HTRANS_IDLE, 32'h0, 1'b0, 3'b000);
    #3;
    chk("t5_hresp_c2", 32'(mst_HRESP), 32'h4);
    chkb("t5_ins_ready", mst_HREADY[2], 1'b1);
    chkb("t5_dat_parked", mst_HREADY[1], 1'b0);
    chk("t5_dat_addr", slv_HADDR, 32'h700);
    chk("t5_dat_trans", 32'(slv_HTRANS), 32'h2);
    cyc();
    slv_HRESP = HRESP_OKAY;
    #3;
    chkb("t5_dat_dph", mst_HREADY[1], 1'b1);
    chk("t5_hresp_ok", 32'(mst_HRESP), 32'h0);

    // 6: reset with dbg parked and dat in data phase
    cyc();
    drv(2'd1, HTRANS_NONSEQ, 32'h800, 1'b1, 3'b000);
    #3;
    chk("t6_dat_addr", slv_HADDR, 32'h800);
    cyc();
    drv(2'd1, HTRANS_IDLE, 32'h0, 1'b0, 3'b000);
    drv(2'd0, HTRANS_NONSEQ, 32'h900, 1'b0, 3'b000);
    slv_HREADY = 1'b0;
    cyc();
    drv(2'd0, HTRANS_NONSEQ, 32'h904, 1'b0, 3'b000);
    #3;
    chk("t6_pre_hready", 32'(mst_HREADY), 32'h4);
    HRESETn = 1'b0;
    #1;
    chk("t6_rst_hready", 32'(mst_HREADY), 32'h7);
    chk("t6_rst_htrans", 32'(slv_HTRANS), 32'h0);
    chkb("t6_rst_hsel", slv_HSEL, 1'b0);
    chk("t6_rst_hwdata", slv_HWDATA, 32'h0);
    cyc();
    idle_all();
    slv_HREADY = 1'b1;
    HRESETn    = 1'b1;
    #3;
    chk("t6_post_hready", 32'(mst_HREADY), 32'h7);
    chk("t6_post_htrans", 32'(slv_HTRANS), 32'h0);

`ifdef AHB3LITE_ARB_RR_EN
    // round-robin: dat and ins requesting continuously alternate
    cyc();
    drv(2'd1, HTRANS_NONSEQ, 32'h1000, 1'b0, 3'b000);
    drv(2'd2, HTRANS_NONSEQ, 32'h2000, 1'b0, 3'b000);
    #3;
    chk("rr_g0", slv_HADDR, 32'h1000);
    cyc();
    #3;
    chk("rr_g1", slv_HADDR, 32'h2000);
    cyc();
    #3;
    chk("rr_g2", slv_HADDR, 32'h1000);
    cyc();
    #3;
    chk("rr_g3", slv_HADDR, 32'h2000);
    cyc();
    idle_all();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
